// File: rtl/axis_rx_mon_pkg.sv
// axis_rx_mon_pkg: backpressure mode encodings, LFSR constants and tkeep helpers
// shared by the RX monitor top and its per-channel statistics block.
package axis_rx_mon_pkg;

    typedef enum logic [1:0] {
        MODE_ALWAYS = 2'd0,
        MODE_NEVER  = 2'd1,
        MODE_DUTY   = 2'd2,
        MODE_RANDOM = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1; bit 15 is the x^16 term.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // The keep helpers take a zero-extended keep vector of this many lanes.
    localparam int MAX_KW = 256;
    localparam int POPW   = 9;

    function automatic logic [POPW-1:0] popcount(input logic [MAX_KW-1:0] v);
        logic [POPW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_KW; i++) begin
            cnt = cnt + POPW'(v[i]);
        end
        return cnt;
    endfunction

    // True when v is 2^k-1 for some k >= 1 (a non-empty run of ones from lane 0).
    function automatic logic keep_contiguous(input logic [MAX_KW-1:0] v);
        return (v != '0) && ((v & (v + MAX_KW'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_rx_chan_stats.sv
// axis_rx_chan_stats: one RX channel's random-ready LFSR, incrementing-byte
// payload checker, sequence counter and beat/packet/byte/error statistics.
module axis_rx_chan_stats
    import axis_rx_mon_pkg::*;
#(
    parameter int          DW   = 128,
    parameter int          CW   = 32,
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   i_tdata,
    input  logic [DW/8-1:0] i_tkeep,
    input  logic            i_tlast,
    input  logic            i_tvalid,
    input  logic            i_tready,
    input  logic            i_clear,
    output logic            o_lfsrBit,
    output logic [CW-1:0]   o_beats,
    output logic [CW-1:0]   o_pkts,
    output logic [CW-1:0]   o_bytes,
    output logic [CW-1:0]   o_errs
);

    localparam int KW = DW / 8;

    logic [15:0]       r_lfsr;
    logic [7:0]        r_seq;
    logic [CW-1:0]     r_beats;
    logic [CW-1:0]     r_pkts;
    logic [CW-1:0]     r_bytes;
    logic [CW-1:0]     r_errs;

    logic              w_lfsrFb;
    logic [MAX_KW-1:0] w_keepExt;
    logic [POPW-1:0]   w_popCnt;
    logic              w_laneErr;
    logic              w_keepErr;
    logic              w_beatErr;
    logic              w_accept;

    assign w_lfsrFb  = ^(r_lfsr & LFSR_TAPS);
    assign w_accept  = i_tvalid & i_tready;
    assign w_popCnt  = popcount(w_keepExt);
    assign w_beatErr = w_laneErr | w_keepErr;

    assign o_lfsrBit = r_lfsr[0];
    assign o_beats   = r_beats;
    assign o_pkts    = r_pkts;
    assign o_bytes   = r_bytes;
    assign o_errs    = r_errs;

    // Widen tkeep to the helper width so the package functions fit any DW.
    always_comb begin
        w_keepExt         = '0;
        w_keepExt[KW-1:0] = i_tkeep;
    end

    // Flag a lane error when any kept lane differs from (seq + lane) mod 256.
    always_comb begin
        w_laneErr = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (i_tkeep[i] && (i_tdata[i*8 +: 8] != (r_seq + 8'(i)))) begin
                w_laneErr = 1'b1;
            end
        end
    end

    // Non-last beats must be full; last beats must be a non-empty low-contiguous run.
    always_comb begin
        if (i_tlast) begin
            w_keepErr = ~keep_contiguous(w_keepExt);
        end else begin
            w_keepErr = (i_tkeep != '1);
        end
    end

    // Free-running Fibonacci LFSR; clear does not touch it, and a zero state reloads the seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else if (r_lfsr == 16'h0000) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end

    // Sequence and statistics update on each accepted beat; clear wins over an accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seq   <= 8'd0;
            r_beats <= '0;
            r_pkts  <= '0;
            r_bytes <= '0;
            r_errs  <= '0;
        end else if (i_clear) begin
            r_seq   <= 8'd0;
            r_beats <= '0;
            r_pkts  <= '0;
            r_bytes <= '0;
            r_errs  <= '0;
        end else if (w_accept) begin
            r_beats <= r_beats + CW'(1);
            r_bytes <= r_bytes + CW'(w_popCnt);
            if (i_tlast) begin
                r_pkts <= r_pkts + CW'(1);
                r_seq  <= 8'd0;
            end else begin
                r_seq  <= r_seq + w_popCnt[7:0];
            end
            if (w_beatErr && (r_errs != '1)) begin
                r_errs <= r_errs + CW'(1);
            end
        end
    end

endmodule

// File: rtl/axis_rx_monitor.sv
// axis_rx_monitor: multi-channel AXI-Stream sink with selectable backpressure,
// per-channel payload checking and a registered statistics readout port.
module axis_rx_monitor
    import axis_rx_mon_pkg::*;
#(
    parameter int DW  = 128,
    parameter int NCH = 2,
    parameter int CW  = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [NCH*DW-1:0]                      s_tdata,
    input  logic [NCH*(DW/8)-1:0]                  s_tkeep,
    input  logic [NCH-1:0]                         s_tlast,
    input  logic [NCH-1:0]                         s_tvalid,
    output logic [NCH-1:0]                         s_tready,
    input  logic [1:0]                             mode,
    input  logic [3:0]                             duty,
    input  logic                                   clear,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] stat_sel,
    output logic [CW-1:0]                          stat_beats,
    output logic [CW-1:0]                          stat_pkts,
    output logic [CW-1:0]                          stat_bytes,
    output logic [CW-1:0]                          stat_errs
);

    localparam int KW   = DW / 8;
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [3:0]     r_dutyCnt;
    logic [NCH-1:0] r_tready;
    logic [CW-1:0]  r_statBeats;
    logic [CW-1:0]  r_statPkts;
    logic [CW-1:0]  r_statBytes;
    logic [CW-1:0]  r_statErrs;

    logic [NCH-1:0] w_readyNext;
    logic [NCH-1:0] w_lfsrBit;
    logic [CW-1:0]  w_beats [NCH];
    logic [CW-1:0]  w_pkts  [NCH];
    logic [CW-1:0]  w_bytes [NCH];
    logic [CW-1:0]  w_errs  [NCH];
    logic [CW-1:0]  w_selBeats;
    logic [CW-1:0]  w_selPkts;
    logic [CW-1:0]  w_selBytes;
    logic [CW-1:0]  w_selErrs;

    assign s_tready   = r_tready;
    assign stat_beats = r_statBeats;
    assign stat_pkts  = r_statPkts;
    assign stat_bytes = r_statBytes;
    assign stat_errs  = r_statErrs;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        axis_rx_chan_stats #(
            .DW   (DW),
            .CW   (CW),
            .SEED (LFSR_SEED ^ 16'(c))
        ) u_chan (
            .clk       (clk),
            .resetn    (resetn),
            .i_tdata   (s_tdata[c*DW +: DW]),
            .i_tkeep   (s_tkeep[c*KW +: KW]),
            .i_tlast   (s_tlast[c]),
            .i_tvalid  (s_tvalid[c]),
            .i_tready  (r_tready[c]),
            .i_clear   (clear),
            .o_lfsrBit (w_lfsrBit[c]),
            .o_beats   (w_beats[c]),
            .o_pkts    (w_pkts[c]),
            .o_bytes   (w_bytes[c]),
            .o_errs    (w_errs[c])
        );
    end

    // Next-cycle tready from the mode alone; tvalid never feeds this path.
    always_comb begin
        w_readyNext = '0;
        for (int c = 0; c < NCH; c++) begin
            case (mode_e'(mode))
                MODE_ALWAYS: w_readyNext[c] = 1'b1;
                MODE_NEVER:  w_readyNext[c] = 1'b0;
                MODE_DUTY:   w_readyNext[c] = (r_dutyCnt < duty);
                MODE_RANDOM: w_readyNext[c] = w_lfsrBit[c];
                default:     w_readyNext[c] = 1'b0;
            endcase
        end
    end

    // Shared duty counter and registered tready; clear leaves both alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dutyCnt <= 4'd0;
            r_tready  <= '0;
        end else begin
            r_dutyCnt <= r_dutyCnt + 4'd1;
            r_tready  <= w_readyNext;
        end
    end

    // Select one channel's counters; a select beyond NCH matches nothing and reads zero.
    always_comb begin
        w_selBeats = '0;
        w_selPkts  = '0;
        w_selBytes = '0;
        w_selErrs  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (stat_sel == SELW'(c)) begin
                w_selBeats = w_beats[c];
                w_selPkts  = w_pkts[c];
                w_selBytes = w_bytes[c];
                w_selErrs  = w_errs[c];
            end
        end
    end

    // Register the readout so stat_* lag stat_sel and counter updates by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_statBeats <= '0;
            r_statPkts  <= '0;
            r_statBytes <= '0;
            r_statErrs  <= '0;
        end else begin
            r_statBeats <= w_selBeats;
            r_statPkts  <= w_selPkts;
            r_statBytes <= w_selBytes;
            r_statErrs  <= w_selErrs;
        end
    end

endmodule

// File: tb/tb_axis_rx_monitor.sv
// tb_axis_rx_monitor: scenario tasks plus randomized traffic for axis_rx_monitor,
// checked against a beat-level reference model of the monitor's rules.
module tb_axis_rx_monitor;

    localparam int DW  = 128;
    localparam int KW  = DW / 8;
    localparam int NCH = 2;
    localparam int CW  = 32;

    logic              clk;
    logic              resetn;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH*KW-1:0] s_tkeep;
    logic [NCH-1:0]    s_tlast;
    logic [NCH-1:0]    s_tvalid;
    logic [NCH-1:0]    s_tready;
    logic [1:0]        mode;
    logic [3:0]        duty;
    logic              clear;
    logic [0:0]        stat_sel;
    logic [CW-1:0]     stat_beats;
    logic [CW-1:0]     stat_pkts;
    logic [CW-1:0]     stat_bytes;
    logic [CW-1:0]     stat_errs;

    int checks;
    int failures;

    // Reference model state
    int             mSeq   [NCH];
    logic [CW-1:0]  mBeats [NCH];
    logic [CW-1:0]  mPkts  [NCH];
    logic [CW-1:0]  mBytes [NCH];
    logic [CW-1:0]  mErrs  [NCH];
    logic [15:0]    mLfsr  [NCH];
    logic [NCH-1:0] mReady;
    int             mDutyCnt;
    logic [CW-1:0]  expBeats;
    logic [CW-1:0]  expPkts;
    logic [CW-1:0]  expBytes;
    logic [CW-1:0]  expErrs;

    axis_rx_monitor #(
        .DW  (DW),
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .mode       (mode),
        .duty       (duty),
        .clear      (clear),
        .stat_sel   (stat_sel),
        .stat_beats (stat_beats),
        .stat_pkts  (stat_pkts),
        .stat_bytes (stat_bytes),
        .stat_errs  (stat_errs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsrNext(input logic [15:0] s, input logic [15:0] seed);
        logic fb;
        if (s == 16'h0000) return seed;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    function automatic bit beatHasError(input int seq, input logic [DW-1:0] d,
                                        input logic [KW-1:0] k, input logic last);
        bit err;
        bit ok;
        err = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (k[i] && (d[i*8 +: 8] != 8'((seq + i) % 256))) err = 1'b1;
        end
        if (!last) begin
            if (k != {KW{1'b1}}) err = 1'b1;
        end else begin
            ok = 1'b0;
            for (int n = 1; n <= KW; n++) begin
                if (k == KW'((64'd1 << n) - 64'd1)) ok = 1'b1;
            end
            if (!ok) err = 1'b1;
        end
        return err;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) begin
            mSeq[c]   = 0;
            mBeats[c] = '0;
            mPkts[c]  = '0;
            mBytes[c] = '0;
            mErrs[c]  = '0;
            mLfsr[c]  = 16'hACE1 ^ 16'(c);
        end
        mReady   = '0;
        mDutyCnt = 0;
        expBeats = '0;
        expPkts  = '0;
        expBytes = '0;
        expErrs  = '0;
    endtask

    // Advance the model across one rising edge with the inputs currently driven,
    // then move to the following falling edge where outputs are sampled.
    task automatic stepCycle();
        logic [NCH-1:0] nextReady;
        logic [KW-1:0]  k;
        logic [DW-1:0]  d;
        int sel;
        sel = int'(stat_sel);
        if (sel < NCH) begin
            expBeats = mBeats[sel];
            expPkts  = mPkts[sel];
            expBytes = mBytes[sel];
            expErrs  = mErrs[sel];
        end else begin
            expBeats = '0;
            expPkts  = '0;
            expBytes = '0;
            expErrs  = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (s_tvalid[c] && mReady[c] && !clear) begin
                k = s_tkeep[c*KW +: KW];
                d = s_tdata[c*DW +: DW];
                mBeats[c] = mBeats[c] + 1;
                mBytes[c] = mBytes[c] + CW'($countones(k));
                if (s_tlast[c]) mPkts[c] = mPkts[c] + 1;
                if (beatHasError(mSeq[c], d, k, s_tlast[c]) && (mErrs[c] != '1)) mErrs[c] = mErrs[c] + 1;
                mSeq[c] = s_tlast[c] ? 0 : (mSeq[c] + $countones(k)) % 256;
            end
        end
        if (clear) begin
            for (int c = 0; c < NCH; c++) begin
                mSeq[c]   = 0;
                mBeats[c] = '0;
                mPkts[c]  = '0;
                mBytes[c] = '0;
                mErrs[c]  = '0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            case (mode)
                2'd0:    nextReady[c] = 1'b1;
                2'd1:    nextReady[c] = 1'b0;
                2'd2:    nextReady[c] = (mDutyCnt < int'(duty));
                default: nextReady[c] = mLfsr[c][0];
            endcase
            mLfsr[c] = lfsrNext(mLfsr[c], 16'hACE1 ^ 16'(c));
        end
        mDutyCnt = (mDutyCnt + 1) % 16;
        mReady   = nextReady;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a valid beat on channel c whose kept lanes follow the model's sequence.
    task automatic driveBeat(input int c, input logic [KW-1:0] keep, input logic last);
        s_tvalid[c]             = 1'b1;
        s_tlast[c]              = last;
        s_tkeep[c*KW +: KW]     = keep;
        for (int i = 0; i < KW; i++) begin
            if (keep[i]) s_tdata[c*DW + i*8 +: 8] = 8'((mSeq[c] + i) % 256);
            else         s_tdata[c*DW + i*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic idleCycle();
        s_tvalid = '0;
        clear    = 1'b0;
        stepCycle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_tready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_tready: got %b expected 00", s_tready);
        end
        checks++;
        if ({stat_beats, stat_pkts, stat_bytes, stat_errs} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_stats: got %0h/%0h/%0h/%0h expected all 0", stat_beats, stat_pkts, stat_bytes, stat_errs);
        end
        resetn = 1'b1;
        modelReset();
        idleCycle();
        checks++;
        if (s_tready !== 2'b11) begin
            failures++;
            $display("[TB] FAIL release_tready: got %b expected 11", s_tready);
        end
        checks++;
        if (stat_beats !== '0 || stat_errs !== '0) begin
            failures++;
            $display("[TB] FAIL release_stats: got beats=%0d errs=%0d expected 0/0", stat_beats, stat_errs);
        end
    endtask

    task automatic test_packet();
        logic [KW-1:0] keeps [3];
        keeps[0] = 16'hFFFF;
        keeps[1] = 16'hFFFF;
        keeps[2] = 16'h00FF;
        stat_sel = 1'b0;
        for (int b = 0; b < 3; b++) begin
            driveBeat(0, keeps[b], (b == 2));
            checks++;
            if (s_tready[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL pkt_ready beat %0d: got %b expected 1", b, s_tready[0]);
            end
            stepCycle();
        end
        idleCycle();
        checks++;
        if (stat_beats !== 32'd3 || stat_pkts !== 32'd1) begin
            failures++;
            $display("[TB] FAIL pkt_counts: got beats=%0d pkts=%0d expected 3/1", stat_beats, stat_pkts);
        end
        checks++;
        if (stat_bytes !== 32'd40 || stat_errs !== 32'd0) begin
            failures++;
            $display("[TB] FAIL pkt_bytes: got bytes=%0d errs=%0d expected 40/0", stat_bytes, stat_errs);
        end
        // Second packet must restart at byte 0
        for (int i = 0; i < KW; i++) s_tdata[i*8 +: 8] = 8'(i);
        s_tkeep[KW-1:0] = 16'hFFFF;
        s_tlast[0]      = 1'b1;
        s_tvalid[0]     = 1'b1;
        stepCycle();
        idleCycle();
        checks++;
        if (stat_errs !== 32'd0 || stat_pkts !== 32'd2 || stat_bytes !== 32'd56) begin
            failures++;
            $display("[TB] FAIL pkt_restart: got errs=%0d pkts=%0d bytes=%0d expected 0/2/56", stat_errs, stat_pkts, stat_bytes);
        end
    endtask

    task automatic test_lane_error();
        stat_sel = 1'b1;
        driveBeat(1, 16'hFFFF, 1'b0);
        s_tdata[DW + 5*8 +: 8] = 8'hFF;
        stepCycle();
        idleCycle();
        checks++;
        if (stat_beats !== 32'd1 || stat_errs !== 32'd1) begin
            failures++;
            $display("[TB] FAIL lane_err: got beats=%0d errs=%0d expected 1/1", stat_beats, stat_errs);
        end
        // Next beat must be checked against seq=16
        for (int i = 0; i < KW; i++) s_tdata[DW + i*8 +: 8] = 8'(16 + i);
        s_tkeep[KW +: KW] = 16'hFFFF;
        s_tlast[1]        = 1'b1;
        s_tvalid[1]       = 1'b1;
        stepCycle();
        idleCycle();
        checks++;
        if (stat_beats !== 32'd2 || stat_errs !== 32'd1 || stat_bytes !== 32'd32) begin
            failures++;
            $display("[TB] FAIL lane_seq: got beats=%0d errs=%0d bytes=%0d expected 2/1/32", stat_beats, stat_errs, stat_bytes);
        end
    endtask

    task automatic test_duty();
        int obs;
        mode     = 2'd2;
        duty     = 4'd4;
        stat_sel = 1'b0;
        idleCycle();
        obs = 0;
        for (int n = 0; n < 64; n++) begin
            driveBeat(0, 16'hFFFF, 1'b0);
            checks++;
            if (s_tready !== mReady) begin
                failures++;
                $display("[TB] FAIL duty_ready cycle %0d: got %b expected %b", n, s_tready, mReady);
            end
            if (s_tready[0]) obs++;
            stepCycle();
        end
        checks++;
        if (obs != 16) begin
            failures++;
            $display("[TB] FAIL duty_accepts: got %0d expected 16", obs);
        end
        idleCycle();
        checks++;
        if (stat_beats !== expBeats || stat_errs !== expErrs) begin
            failures++;
            $display("[TB] FAIL duty_stats: got beats=%0d errs=%0d expected %0d/%0d", stat_beats, stat_errs, expBeats, expErrs);
        end
    endtask

    task automatic test_clear();
        mode     = 2'd0;
        stat_sel = 1'b0;
        idleCycle();
        driveBeat(0, 16'hFFFF, 1'b0);
        clear = 1'b1;
        stepCycle();
        clear    = 1'b0;
        s_tvalid = '0;
        stepCycle();
        checks++;
        if ({stat_beats, stat_pkts, stat_bytes, stat_errs} !== '0) begin
            failures++;
            $display("[TB] FAIL clear_ch0: got %0d/%0d/%0d/%0d expected all 0", stat_beats, stat_pkts, stat_bytes, stat_errs);
        end
        stat_sel = 1'b1;
        idleCycle();
        checks++;
        if ({stat_beats, stat_pkts, stat_bytes, stat_errs} !== '0) begin
            failures++;
            $display("[TB] FAIL clear_ch1: got %0d/%0d/%0d/%0d expected all 0", stat_beats, stat_pkts, stat_bytes, stat_errs);
        end
        stat_sel = 1'b0;
        for (int i = 0; i < KW; i++) s_tdata[i*8 +: 8] = 8'(i);
        s_tkeep[KW-1:0] = 16'hFFFF;
        s_tlast[0]      = 1'b1;
        s_tvalid[0]     = 1'b1;
        stepCycle();
        idleCycle();
        checks++;
        if (stat_beats !== 32'd1 || stat_errs !== 32'd0 || stat_bytes !== 32'd16) begin
            failures++;
            $display("[TB] FAIL clear_seq: got beats=%0d errs=%0d bytes=%0d expected 1/0/16", stat_beats, stat_errs, stat_bytes);
        end
    endtask

    task automatic test_saturate();
        stat_sel = 1'b1;
        force dut.g_chan[1].u_chan.r_errs = 32'hFFFF_FFFE;
        force dut.g_chan[1].u_chan.r_pkts = 32'hFFFF_FFFF;
        mErrs[1] = 32'hFFFF_FFFE;
        mPkts[1] = 32'hFFFF_FFFF;
        idleCycle();
        release dut.g_chan[1].u_chan.r_errs;
        release dut.g_chan[1].u_chan.r_pkts;
        driveBeat(1, 16'h0000, 1'b1);
        stepCycle();
        idleCycle();
        checks++;
        if (stat_errs !== 32'hFFFF_FFFF || stat_pkts !== 32'd0) begin
            failures++;
            $display("[TB] FAIL sat_first: got errs=%0h pkts=%0h expected ffffffff/0", stat_errs, stat_pkts);
        end
        driveBeat(1, 16'h0F0F, 1'b1);
        stepCycle();
        idleCycle();
        checks++;
        if (stat_errs !== 32'hFFFF_FFFF || stat_pkts !== 32'd1) begin
            failures++;
            $display("[TB] FAIL sat_hold: got errs=%0h pkts=%0h expected ffffffff/1", stat_errs, stat_pkts);
        end
    endtask

    task automatic test_random();
        logic [KW-1:0] k;
        logic          last;
        int            lane;
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                mode = 2'($urandom_range(0, 3));
                duty = 4'($urandom);
            end
            stat_sel = 1'($urandom);
            clear    = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    last = ($urandom_range(0, 3) == 0);
                    if (last) begin
                        if ($urandom_range(0, 3) != 0) k = KW'((64'd1 << $urandom_range(1, KW)) - 64'd1);
                        else                           k = KW'($urandom);
                    end else begin
                        if ($urandom_range(0, 6) != 0) k = '1;
                        else                           k = KW'($urandom);
                    end
                    driveBeat(c, k, last);
                    if ($urandom_range(0, 7) == 0) begin
                        lane = $urandom_range(0, KW - 1);
                        s_tdata[c*DW + lane*8 +: 8] = s_tdata[c*DW + lane*8 +: 8] ^ 8'($urandom_range(1, 255));
                    end
                end else begin
                    s_tvalid[c] = 1'b0;
                end
            end
            stepCycle();
            checks++;
            if (s_tready !== mReady) begin
                failures++;
                $display("[TB] FAIL rnd_ready cycle %0d: got %b expected %b", n, s_tready, mReady);
            end
            checks++;
            if (stat_beats !== expBeats || stat_pkts !== expPkts) begin
                failures++;
                $display("[TB] FAIL rnd_beats_pkts cycle %0d: got %0d/%0d expected %0d/%0d", n, stat_beats, stat_pkts, expBeats, expPkts);
            end
            checks++;
            if (stat_bytes !== expBytes || stat_errs !== expErrs) begin
                failures++;
                $display("[TB] FAIL rnd_bytes_errs cycle %0d: got %0d/%0d expected %0d/%0d", n, stat_bytes, stat_errs, expBytes, expErrs);
            end
        end
        clear = 1'b0;
        idleCycle();
    endtask

    task automatic test_reset_mid_packet();
        mode     = 2'd0;
        stat_sel = 1'b0;
        idleCycle();
        driveBeat(0, 16'hFFFF, 1'b0);
        stepCycle();
        s_tvalid = '0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (s_tready !== 2'b00 || stat_beats !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_async: got tready=%b beats=%0d expected 00/0", s_tready, stat_beats);
        end
        @(negedge clk);
        resetn = 1'b1;
        modelReset();
        idleCycle();
        for (int i = 0; i < KW; i++) s_tdata[i*8 +: 8] = 8'(i);
        s_tkeep[KW-1:0] = 16'h0007;
        s_tlast[0]      = 1'b1;
        s_tvalid[0]     = 1'b1;
        stepCycle();
        idleCycle();
        checks++;
        if (stat_beats !== 32'd1 || stat_errs !== 32'd0 || stat_bytes !== 32'd3) begin
            failures++;
            $display("[TB] FAIL midrst_restart: got beats=%0d errs=%0d bytes=%0d expected 1/0/3", stat_beats, stat_errs, stat_bytes);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        mode     = 2'd0;
        duty     = 4'd0;
        clear    = 1'b0;
        stat_sel = 1'b0;
        modelReset();
        test_reset();
        test_packet();
        test_lane_error();
        test_duty();
        test_clear();
        test_saturate();
        test_random();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
